// File: rtl/draw_pkg.sv
// draw_pkg: shared types, field-word layout, FSM states and Q16.16 helpers
package draw_pkg;
    typedef logic signed [31:0] q16_t;
    typedef logic signed [15:0] coord_t;
    typedef logic signed [17:0] delta_t;
    localparam int XN_MSB = 95;
    localparam int XN_LSB = 64;
    localparam int YN_MSB = 63;
    localparam int YN_LSB = 32;
    localparam int MAG_MSB = 31;
    localparam int MAG_LSB = 0;
    localparam q16_t Q_ONE = 32'sh0001_0000;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, SETUP, DRAW, NEXT, DONE} state_t;
    function automatic q16_t clamp_unit(q16_t v);
        return v > Q_ONE ? Q_ONE : v < -Q_ONE ? -Q_ONE : v;
    endfunction
    function automatic delta_t widen(coord_t v);
        return delta_t'(v);
    endfunction
endpackage

// File: rtl/vector_line_renderer_if.sv
// vector_line_renderer_if: frame control, field-memory read port and framebuffer write port
interface vector_line_renderer_if #(
    parameter int FIELD_ADDRW = 6,
    parameter int DRAW_ADDRW = 17,
    parameter int DRAW_DATAW = 4
);
    logic start, busy, done, draw_we;
    logic [FIELD_ADDRW-1:0] field_addr;
    logic [95:0] field_data;
    logic [DRAW_ADDRW-1:0] draw_addr;
    logic [DRAW_DATAW-1:0] draw_data;
    modport master (output start, field_data, input busy, done, field_addr, draw_addr, draw_data, draw_we);
    modport slave (input start, field_data, output busy, done, field_addr, draw_addr, draw_data, draw_we);
endinterface

// File: rtl/line_stepper.sv
// line_stepper: Bresenham walker emitting one pixel per step from start to end point inclusive
module line_stepper
    import draw_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   step_i,
    input  coord_t x0_i,
    input  coord_t y0_i,
    input  coord_t x1_i,
    input  coord_t y1_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   last_o
);
    coord_t x_q, y_q, x1_q, y1_q, sx_q, sy_q;
    delta_t dx_q, dy_q, err_q, ddx, ddy, adx, ndy, e2;
    logic mx, my;
    always_comb begin
        ddx = widen(x1_i) - widen(x0_i);
        ddy = widen(y1_i) - widen(y0_i);
        adx = ddx[17] ? -ddx : ddx;
        ndy = ddy[17] ? ddy : -ddy;
        e2 = err_q <<< 1;
        mx = e2 >= dy_q;
        my = e2 <= dx_q;
    end
    assign x_o = x_q;
    assign y_o = y_q;
    assign last_o = (x_q == x1_q) && (y_q == y1_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {x_q, y_q, x1_q, y1_q, sx_q, sy_q} <= '0;
            {dx_q, dy_q, err_q} <= '0;
        end else if (load_i) begin
            x_q <= x0_i;
            y_q <= y0_i;
            x1_q <= x1_i;
            y1_q <= y1_i;
            dx_q <= adx;
            dy_q <= ndy;
            err_q <= adx + ndy;
            sx_q <= ddx[17] ? -16'sd1 : 16'sd1;
            sy_q <= ddy[17] ? -16'sd1 : 16'sd1;
        end else if (step_i && !last_o) begin
            x_q <= mx ? x_q + sx_q : x_q;
            y_q <= my ? y_q + sy_q : y_q;
            err_q <= err_q + (mx ? dy_q : '0) + (my ? dx_q : '0);
        end
    end
endmodule

// File: rtl/vector_line_renderer.sv
// vector_line_renderer: renders one clamped, intensity-weighted vector per field cell into a framebuffer
module vector_line_renderer
    import draw_pkg::*;
#(
    parameter int DRAW_WIDTH   = 320,
    parameter int DRAW_HEIGHT  = 240,
    parameter int FIELD_WIDTH  = 10,
    parameter int FIELD_HEIGHT = 6,
    parameter int DRAW_DATAW   = 4,
    parameter int FIELD_RD_LAT = 1,
    parameter int CLEAR_EN     = 1
) (
    input logic clk,
    input logic rst_n,
    vector_line_renderer_if.slave bus
);
    localparam int FIELD_SCALE = DRAW_WIDTH / FIELD_WIDTH;
    localparam int FIELD_ADDRW = $clog2(FIELD_WIDTH * FIELD_HEIGHT);
    localparam int DRAW_ADDRW = $clog2(DRAW_WIDTH * DRAW_HEIGHT);
    localparam int HALF = FIELD_SCALE / 2;
    localparam logic [DRAW_ADDRW-1:0] CLR_END = DRAW_ADDRW'(DRAW_WIDTH * DRAW_HEIGHT - 1);
    localparam logic [FIELD_ADDRW-1:0] CELL_END = FIELD_ADDRW'(FIELD_WIDTH * FIELD_HEIGHT - 1);
    localparam logic [2:0] LAT_END = 3'(FIELD_RD_LAT - 1);
    localparam coord_t COL_END = coord_t'(FIELD_WIDTH - 1);
    localparam coord_t X_LIM = coord_t'(DRAW_WIDTH);
    localparam coord_t Y_LIM = coord_t'(DRAW_HEIGHT);
    localparam logic [15:0] I_MAX = 16'(2 ** DRAW_DATAW - 1);
    localparam logic signed [47:0] HALF_W = 48'(HALF);

    state_t state_q, state_d;
    logic [DRAW_ADDRW-1:0] clr_q, clr_d, addr_q, addr_d;
    logic [FIELD_ADDRW-1:0] cell_q, cell_d;
    logic [2:0] lat_q, lat_d;
    logic [DRAW_DATAW-1:0] inten_q, inten_d, inten, data_q, data_d;
    logic [15:0] mag_q;
    q16_t xn_q, yn_q;
    coord_t col_q, col_d, row_q, row_d, cx, cy, ex, ey, px, py;
    logic signed [47:0] xw, yw, xs, ys;
    logic we_q, we_d, cap, load, step, last, inb;

    line_stepper u_step (
        .clk(clk), .rst_n(rst_n), .load_i(load), .step_i(step),
        .x0_i(cx), .y0_i(cy), .x1_i(ex), .y1_i(ey),
        .x_o(px), .y_o(py), .last_o(last)
    );

    // Endpoint offset is the clamped unit vector scaled to half a cell, rounded to nearest
    always_comb begin
        xw = clamp_unit(xn_q);
        yw = clamp_unit(yn_q);
        xs = xw * HALF_W + 48'sh8000;
        ys = yw * HALF_W + 48'sh8000;
        cx = coord_t'(int'(col_q) * FIELD_SCALE + HALF);
        cy = coord_t'(int'(row_q) * FIELD_SCALE + HALF);
        ex = cx + coord_t'(xs >>> 16);
        ey = cy + coord_t'(ys >>> 16);
        inten = mag_q[15] ? '0 : mag_q > I_MAX ? '1 : mag_q[DRAW_DATAW-1:0];
        inb = !px[15] && !py[15] && px < X_LIM && py < Y_LIM;
    end

    always_comb begin
        state_d = state_q;
        clr_d = clr_q;
        cell_d = cell_q;
        col_d = col_q;
        row_d = row_q;
        lat_d = lat_q;
        inten_d = inten_q;
        we_d = 1'b0;
        addr_d = '0;
        data_d = '0;
        cap = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                {cell_d, col_d, row_d, clr_d} = '0;
                state_d = CLEAR_EN != 0 ? CLEAR : FETCH;
            end
            CLEAR: begin
                we_d = 1'b1;
                addr_d = clr_q;
                clr_d = clr_q + DRAW_ADDRW'(1);
                state_d = clr_q == CLR_END ? FETCH : CLEAR;
            end
            FETCH: begin
                lat_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q + 3'd1;
                cap = lat_q == LAT_END;
                state_d = cap ? SETUP : WAIT;
            end
            SETUP: begin
                load = 1'b1;
                inten_d = inten;
                state_d = inten == '0 ? NEXT : DRAW;
            end
            DRAW: begin
                step = 1'b1;
                we_d = inb;
                addr_d = DRAW_ADDRW'(int'(py) * DRAW_WIDTH + int'(px));
                data_d = inten_q;
                state_d = last ? NEXT : DRAW;
            end
            NEXT: begin
                state_d = cell_q == CELL_END ? DONE : FETCH;
                cell_d = cell_q == CELL_END ? cell_q : cell_q + FIELD_ADDRW'(1);
                col_d = cell_q == CELL_END ? col_q : col_q == COL_END ? '0 : col_q + 16'sd1;
                row_d = cell_q != CELL_END && col_q == COL_END ? row_q + 16'sd1 : row_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            {clr_q, addr_q, cell_q, lat_q, inten_q, data_q, mag_q, we_q} <= '0;
            {xn_q, yn_q, col_q, row_q} <= '0;
        end else begin
            state_q <= state_d;
            clr_q <= clr_d;
            addr_q <= addr_d;
            cell_q <= cell_d;
            col_q <= col_d;
            row_q <= row_d;
            lat_q <= lat_d;
            inten_q <= inten_d;
            data_q <= data_d;
            we_q <= we_d;
            if (cap) begin
                xn_q <= bus.field_data[XN_MSB:XN_LSB];
                yn_q <= bus.field_data[YN_MSB:YN_LSB];
                mag_q <= bus.field_data[MAG_MSB:MAG_LSB+16];
            end
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.field_addr = cell_q;
    assign bus.draw_addr = addr_q;
    assign bus.draw_data = data_q;
    assign bus.draw_we = we_q;
endmodule

// File: tb/tb_vector_line_renderer.sv
// tb_vector_line_renderer: directed frames on a clearing instance and a non-clearing instance
module tb_vector_line_renderer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_line_renderer_if #(.FIELD_ADDRW(6), .DRAW_ADDRW(17), .DRAW_DATAW(4)) aif ();
    vector_line_renderer_if #(.FIELD_ADDRW(6), .DRAW_ADDRW(17), .DRAW_DATAW(4)) bif ();

    vector_line_renderer #(.CLEAR_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(aif));
    vector_line_renderer #(.CLEAR_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bif));

    logic [95:0] mem_b [64];
    assign aif.field_data = '0;
    always @(posedge clk) bif.field_data <= mem_b[bif.field_addr];

    int vecs = 0, errs = 0;
    int a_wr = 0, a_nz = 0, a_max = 0, a_busy = 0, a_done = 0;
    int b_busy = 0, b_done = 0;
    int wq[$];
    int exp_q[$];

    always @(negedge clk) begin
        if (aif.draw_we) begin
            a_wr++;
            if (aif.draw_data != 0) a_nz++;
            if (int'(aif.draw_addr) > a_max) a_max = int'(aif.draw_addr);
        end
        if (aif.busy && !aif.done) a_busy++;
        if (aif.done) a_done++;
        if (bif.draw_we) wq.push_back(int'({bif.draw_addr, bif.draw_data}));
        if (bif.busy && !bif.done) b_busy++;
        if (bif.done) b_done++;
    end

    function automatic int pk(input int a, input int d);
        return a * 16 + d;
    endfunction

    task automatic check(input string tag, input int got, input int want);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic run_b_frame(input bit restart_mid);
        int ws, bb0, bd0;
        ws = wq.size();
        bb0 = b_busy;
        bd0 = b_done;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        check("b_busy_after_start", int'(bif.busy), 1);
        if (restart_mid) begin
            repeat (40) @(negedge clk);
            bif.start = 1'b1;
            @(negedge clk);
            bif.start = 1'b0;
        end
        for (int n = 0; n < 2000 && b_done == bd0; n++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("b_done_count", b_done - bd0, 1);
        check("b_busy_cycles", b_busy - bb0, 310);
        check("b_idle_after", int'(bif.busy), 0);
        check("b_write_count", wq.size() - ws, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("b_write_%0d", i), (ws + i < wq.size()) ? wq[ws + i] : -1, exp_q[i]);
    endtask

    initial begin
        int bd;
        int d13 [9] = '{15472, 15793, 15794, 16115, 16116, 16437, 16438, 16759, 16760};
        foreach (mem_b[i]) mem_b[i] = '0;
        mem_b[0]  = {32'h0001_0000, 32'h0000_0000, 32'h0003_0000};
        mem_b[1]  = {32'h0000_0000, 32'h0000_0000, 32'h0014_0000};
        mem_b[2]  = {32'h0001_0000, 32'h0000_0000, 32'hFFFF_0000};
        mem_b[9]  = {32'h0001_0000, 32'h0000_0000, 32'h0002_0000};
        mem_b[11] = {32'h0003_0000, 32'h0000_0000, 32'h0001_0000};
        mem_b[12] = {32'h0000_0000, 32'hFFFF_8000, 32'h0005_0000};
        mem_b[13] = {32'h0000_8000, 32'h0000_4000, 32'h0007_0000};
        for (int i = 0; i < 17; i++) exp_q.push_back(pk(5136 + i, 3));
        exp_q.push_back(pk(5168, 15));
        for (int i = 0; i < 16; i++) exp_q.push_back(pk(5424 + i, 2));
        for (int i = 0; i < 17; i++) exp_q.push_back(pk(15408 + i, 1));
        for (int i = 0; i < 9; i++) exp_q.push_back(pk((48 - i) * 320 + 80, 5));
        foreach (d13[i]) exp_q.push_back(pk(d13[i], 7));
        aif.start = 1'b0;
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bif.busy), 0);
        check("rst_done", int'(bif.done), 0);
        check("rst_we", int'(bif.draw_we), 0);
        check("rst_draw_addr", int'(bif.draw_addr), 0);
        check("rst_field_addr", int'(bif.field_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        aif.start = 1'b1;
        @(negedge clk);
        aif.start = 1'b0;
        check("a_busy_after_start", int'(aif.busy), 1);
        for (int n = 0; n < 80000 && a_done == 0; n++) @(negedge clk);
        @(negedge clk);
        check("a_done_count", a_done, 1);
        check("a_clear_writes", a_wr, 76800);
        check("a_nonzero_writes", a_nz, 0);
        check("a_max_addr", a_max, 76799);
        check("a_busy_cycles", a_busy, 77040);

        run_b_frame(1'b1);

        bd = b_done;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        for (int n = 0; n < 200 && !bif.draw_we; n++) @(negedge clk);
        check("b_draw_seen", int'(bif.draw_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", int'(bif.draw_we), 0);
        check("mid_rst_busy", int'(bif.busy), 0);
        check("mid_rst_draw_addr", int'(bif.draw_addr), 0);
        check("mid_rst_draw_data", int'(bif.draw_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abandoned_no_done", b_done - bd, 0);

        run_b_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/vector_line_renderer.md
VECTOR_LINE_RENDERER -- requirements
Module: vector_line_renderer

Interface
REQ-001 SHALL have parameter DRAW_WIDTH, default 320, framebuffer width in pixels.
REQ-002 SHALL have parameter DRAW_HEIGHT, default 240, framebuffer height in pixels.
REQ-003 SHALL have parameter FIELD_WIDTH, default 10, field columns.
REQ-004 SHALL have parameter FIELD_HEIGHT, default 6, field rows.
REQ-005 SHALL have parameter DRAW_DATAW, default 4, pixel intensity width.
REQ-006 SHALL have parameter FIELD_RD_LAT, default 1, field-memory read latency in cycles (1..4).
REQ-007 SHALL have parameter CLEAR_EN, default 1; when set, the framebuffer is cleared before drawing.
REQ-008 SHALL have derived constants FIELD_SCALE = DRAW_WIDTH/FIELD_WIDTH, FIELD_ADDRW = $clog2(FIELD_WIDTH*FIELD_HEIGHT), DRAW_ADDRW = $clog2(DRAW_WIDTH*DRAW_HEIGHT).
REQ-009 SHALL have one clock and an asynchronous, active-low reset: clk input 1 bit, system clock; rst_n input 1 bit, asynchronous active-low reset.
REQ-010 SHALL have the port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-011 SHALL have the port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-012 SHALL have the port done, output, 1 bit: one-cycle pulse at frame end.
REQ-013 SHALL have the port field_addr, output, FIELD_ADDRW bits: field cell index, row-major.
REQ-014 SHALL have the port field_data, input, 96 bits: {xn[95:64], yn[63:32], mag[31:0]}, each signed Q16.16.
REQ-015 SHALL have the ports draw_addr (output, DRAW_ADDRW bits, y*DRAW_WIDTH+x), draw_data (output, DRAW_DATAW bits) and draw_we (output, 1 bit, write strobe).

Function
REQ-016 SHALL implement states IDLE, CLEAR, FETCH, WAIT, SETUP, DRAW, NEXT and DONE.
REQ-017 SHALL, in IDLE with start=1, go to CLEAR if CLEAR_EN, else to FETCH with cell=0.
REQ-018 SHALL, in CLEAR, write draw_data=0 to addresses 0..DRAW_SIZE-1, one per cycle, then go to FETCH.
REQ-019 SHALL, in FETCH, drive field_addr=cell for one cycle, then spend FIELD_RD_LAT cycles in WAIT, then capture field_data.
REQ-020 SHALL, in SETUP, clamp xn and yn to [-1.0,+1.0].
REQ-021 SHALL, in SETUP, set center cx = col*FIELD_SCALE + FIELD_SCALE/2 and cy = row*FIELD_SCALE + FIELD_SCALE/2.
REQ-022 SHALL, in SETUP, set endpoint ex = cx + ((xn*(FIELD_SCALE/2) + 0x8000) >>> 16), with ey formed likewise from yn and cy; y grows downward.
REQ-023 SHALL set intensity = integer part of mag, saturated to 2^DRAW_DATAW-1; a negative mag gives 0.
REQ-024 SHALL, when intensity = 0, skip DRAW and go directly to NEXT.
REQ-025 SHALL, in DRAW, step a Bresenham line from (cx,cy) to (ex,ey) inclusive, one pixel per cycle, producing max(|dx|,|dy|)+1 pixels.
REQ-026 SHALL, for each DRAW pixel, drive draw_data=intensity.
REQ-027 SHALL hold draw_we low for pixels with x<0, x>=DRAW_WIDTH, y<0 or y>=DRAW_HEIGHT (clipped), while stepping continues.
REQ-028 SHALL, in NEXT, increment cell, or go to DONE after the last cell.
REQ-029 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL give each drawn cell 3+FIELD_RD_LAT+pixels cycles, and each skipped cell 3+FIELD_RD_LAT cycles.
REQ-032 SHALL assert draw_we only in CLEAR or in DRAW for in-bounds pixels.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously force state=IDLE and busy, done and draw_we to 0.
REQ-034 SHALL, on rst_n=0, asynchronously force draw_addr, draw_data and field_addr to 0.
REQ-035 SHALL, on reset mid-frame, abandon the frame without a done pulse; the next start begins a full new frame.

Structure
REQ-036 SHALL place the Q16.16 typedef, the field-word bit ranges and the state enum in package draw_pkg.
REQ-037 SHALL implement Bresenham stepping in sub-module line_stepper (load, start/end points, step, pixel x/y, last flag).

Verification
REQ-038 SHALL cover all-zero mag, CLEAR_EN=1 -> 76800 clear writes, no DRAW writes, one done after 76800+60*(3+FIELD_RD_LAT) cycles plus state overhead.
REQ-039 SHALL cover cell 0 with xn=0x00010000, yn=0, mag=0x00030000 -> 17 writes at addresses 5136..5152, draw_data=3.
REQ-040 SHALL cover cell 9 with xn=+1.0, mag=2.0 -> x 304..320; 16 writes (5424..5439) and x=320 clipped.
REQ-041 SHALL cover mag=20.0 with DRAW_DATAW=4 -> draw_data=15; mag=-1.0 -> cell skipped.
REQ-042 SHALL cover start pulsed again mid-frame -> ignored, exactly one done.
REQ-043 SHALL cover rst_n low during DRAW -> draw_we=0 and busy=0 immediately; a fresh start completes normally.
